// File: rtl/reg_sequencer_pkg.sv
// Shared types for the register-file sequencer: opcodes, ALU operations,
// FSM states and instruction field positions.
package seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_JMP  = 4'h7,
    OP_BEQZ = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  // Encoding is shared with the external ALU.
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

endpackage

// File: rtl/reg_sequencer_decode.sv
// Combinational instruction decoder: splits IR into register fields and
// control strobes; opcodes 9..E fall through to NOP behaviour.
module instr_decode
  import seq_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  rd_o,
  output logic [3:0]  rs1_o,
  output logic [3:0]  rs2_o,
  output logic [7:0]  imm8_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_src_o,
  output logic        reg_write_o,
  output logic        is_jmp_o,
  output logic        is_beqz_o,
  output logic        is_halt_o
);

  opcode_e op;
  logic    writes;

  assign op     = opcode_e'(ir_i[OP_MSB:OP_LSB]);
  assign rd_o   = ir_i[RD_MSB:RD_LSB];
  assign rs1_o  = ir_i[RS1_MSB:RS1_LSB];
  assign rs2_o  = ir_i[RS2_MSB:RS2_LSB];
  assign imm8_o = {rs1_o, rs2_o};

  always_comb begin
    alu_op_o  = ALU_ADD;
    alu_src_o = 1'b0;
    writes    = 1'b0;
    is_jmp_o  = 1'b0;
    is_beqz_o = 1'b0;
    is_halt_o = 1'b0;
    case (op)
      OP_ADD:  begin alu_op_o = ALU_ADD; writes = 1'b1; end
      OP_SUB:  begin alu_op_o = ALU_SUB; writes = 1'b1; end
      OP_AND:  begin alu_op_o = ALU_AND; writes = 1'b1; end
      OP_OR:   begin alu_op_o = ALU_OR;  writes = 1'b1; end
      OP_XOR:  begin alu_op_o = ALU_XOR; writes = 1'b1; end
      OP_LDI:  begin alu_op_o = ALU_PASSB; alu_src_o = 1'b1; writes = 1'b1; end
      OP_JMP:  is_jmp_o  = 1'b1;
      OP_BEQZ: is_beqz_o = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      default: ;
    endcase
  end

  // r0 is hard-wired to zero, so writes targeting it are dropped here.
  assign reg_write_o = writes && (rd_o != 4'd0);

endmodule

// File: rtl/reg_sequencer.sv
// Three-cycle FETCH/DECODE/EXEC sequencer driving register-file and ALU
// control from a 16-bit instruction ROM; owns pc, IR and the FSM.
module reg_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [15:0]     instr,
  input  logic [7:0]      RD1,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      RA1,
  output logic [3:0]      RA2,
  output logic [3:0]      WA,
  output logic            write_enable,
  output logic [2:0]      alu_op,
  output logic            alu_src,
  output logic [7:0]      imm,
  output logic            busy,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0] rd, rs1, rs2;
  logic [7:0] imm8;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src, reg_write, is_jmp, is_beqz, is_halt;

  instr_decode u_decode (
    .ir_i        (ir_q),
    .rd_o        (rd),
    .rs1_o       (rs1),
    .rs2_o       (rs2),
    .imm8_o      (imm8),
    .alu_op_o    (dec_alu_op),
    .alu_src_o   (dec_alu_src),
    .reg_write_o (reg_write),
    .is_jmp_o    (is_jmp),
    .is_beqz_o   (is_beqz),
    .is_halt_o   (is_halt)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    write_enable = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // Combinational strobe off the async-reset state, so reset kills it at once.
        write_enable = reg_write;
        if (is_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_FETCH;
          if (is_jmp)
            pc_d = PC_W'(imm8);
          else if (is_beqz && (RD1 == 8'd0))
            pc_d = PC_W'({rd, rs2});
          else
            pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc      = pc_q;
  assign RA1     = rs1;
  assign RA2     = rs2;
  assign WA      = rd;
  assign alu_op  = dec_alu_op;
  assign alu_src = dec_alu_src;
  assign imm     = imm8;
  assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted  = (state_q == S_HALTED);

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: ROM, register file and ALU models around the DUT,
// a per-instruction vector table and directed multi-cycle sequences.
module tb_reg_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [15:0] instr;
  logic [7:0]  RD1;
  logic [7:0]  pc;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic [7:0]  imm;
  logic        busy, halted;

  logic [15:0] rom [256];
  logic [7:0]  rf [16];
  logic        load_rf;
  logic [7:0]  rd2, alu_b, alu_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  reg_sequencer #(.PC_W(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .instr        (instr),
    .RD1          (RD1),
    .pc           (pc),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .write_enable (write_enable),
    .alu_op       (alu_op),
    .alu_src      (alu_src),
    .imm          (imm),
    .busy         (busy),
    .halted       (halted)
  );

  // Datapath models: ROM, register file (stored as-is, r0 included) and ALU.
  assign instr = rom[pc];
  assign RD1   = rf[RA1];
  assign rd2   = rf[RA2];
  assign alu_b = alu_src ? imm : rd2;

  always_comb begin
    alu_res = 8'h00;
    case (alu_op)
      3'd0: alu_res = RD1 + alu_b;
      3'd1: alu_res = RD1 - alu_b;
      3'd2: alu_res = RD1 & alu_b;
      3'd3: alu_res = RD1 | alu_b;
      3'd4: alu_res = RD1 ^ alu_b;
      3'd5: alu_res = alu_b;
      default: alu_res = 8'hEE;
    endcase
  end

  always @(posedge CLK) begin
    if (load_rf) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'(i);
    end else if (write_enable) begin
      rf[WA] <= alu_res;
    end
  end

  typedef struct {
    logic [15:0] instr;
    logic        we;
    logic [3:0]  wa;
    logic        chk_alu;
    logic [2:0]  op;
    logic        src;
    logic [7:0]  imm;
    logic        chk_pc;
    logic [7:0]  npc;
    logic        hlt;
    logic [7:0]  res;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    start   = 1'b0;
    load_rf = 1'b1;
    @(posedge CLK);
    #1;
    load_rf = 1'b0;
    RESET   = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    RESET   = 1'b1;
    start   = 1'b0;
    load_rf = 1'b1;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

    //                instr     we  wa   alu op    src imm    pcc npc    hlt res
    vecs[0]  = '{16'h1512, 1'b1, 4'h5, 1'b1, 3'd0, 1'b0, 8'h12, 1'b1, 8'h01, 1'b0, 8'h03};
    vecs[1]  = '{16'h2694, 1'b1, 4'h6, 1'b1, 3'd1, 1'b0, 8'h94, 1'b1, 8'h01, 1'b0, 8'h05};
    vecs[2]  = '{16'h37CA, 1'b1, 4'h7, 1'b1, 3'd2, 1'b0, 8'hCA, 1'b1, 8'h01, 1'b0, 8'h08};
    vecs[3]  = '{16'h485A, 1'b1, 4'h8, 1'b1, 3'd3, 1'b0, 8'h5A, 1'b1, 8'h01, 1'b0, 8'h0F};
    vecs[4]  = '{16'h59F3, 1'b1, 4'h9, 1'b1, 3'd4, 1'b0, 8'hF3, 1'b1, 8'h01, 1'b0, 8'h0C};
    vecs[5]  = '{16'h635C, 1'b1, 4'h3, 1'b1, 3'd5, 1'b1, 8'h5C, 1'b1, 8'h01, 1'b0, 8'h5C};
    vecs[6]  = '{16'h60AA, 1'b0, 4'h0, 1'b1, 3'd5, 1'b1, 8'hAA, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[7]  = '{16'h7040, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 8'h40, 1'b1, 8'h40, 1'b0, 8'h00};
    vecs[8]  = '{16'h8400, 1'b0, 4'h4, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00};
    vecs[9]  = '{16'h8470, 1'b0, 4'h4, 1'b0, 3'd0, 1'b0, 8'h70, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[10] = '{16'hB123, 1'b0, 4'h1, 1'b0, 3'd0, 1'b0, 8'h23, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[11] = '{16'h0000, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[12] = '{16'hF000, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[13] = '{16'h2F12, 1'b1, 4'hF, 1'b1, 3'd1, 1'b0, 8'h12, 1'b1, 8'h01, 1'b0, 8'hFF};

    // Reset state, sampled while reset is still asserted.
    #3;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ra1", RA1, 4'h0);
    chk("rst_ra2", RA2, 4'h0);
    chk("rst_wa", WA, 4'h0);
    chk("rst_we", write_enable, 1'b0);
    chk("rst_aluop", alu_op, 3'd0);
    chk("rst_alusrc", alu_src, 1'b0);
    chk("rst_imm", imm, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    do_reset();

    // Single-instruction vectors, each from a fresh reset with rf[i] = i.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      rom[0] = vecs[i].instr;
      w = vecs[i].instr;
      begin_run();
      chk($sformatf("v%0d_fetch_pc", i), pc, 8'h00);
      chk($sformatf("v%0d_fetch_busy", i), busy, 1'b1);
      tick();
      chk($sformatf("v%0d_ra1", i), RA1, w[7:4]);
      chk($sformatf("v%0d_ra2", i), RA2, w[3:0]);
      tick();
      chk($sformatf("v%0d_we", i), write_enable, vecs[i].we);
      if (vecs[i].we) chk($sformatf("v%0d_wa", i), WA, vecs[i].wa);
      if (vecs[i].chk_alu) begin
        chk($sformatf("v%0d_aluop", i), alu_op, vecs[i].op);
        chk($sformatf("v%0d_alusrc", i), alu_src, vecs[i].src);
        chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      end
      tick();
      if (vecs[i].chk_pc) chk($sformatf("v%0d_next_pc", i), pc, vecs[i].npc);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].hlt);
      chk($sformatf("v%0d_busy", i), busy, !vecs[i].hlt);
      if (vecs[i].we) chk($sformatf("v%0d_result", i), rf[vecs[i].wa], vecs[i].res);
      chk($sformatf("v%0d_r0_zero", i), rf[0], 8'h00);
    end

    // Reset in the middle of an ADD's EXEC aborts the write.
    do_reset();
    rom[0] = 16'h1512;
    begin_run();
    tick();
    tick();
    chk("midrst_we_before", write_enable, 1'b1);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_we", write_enable, 1'b0);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_halted", halted, 1'b0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    tick();
    chk("midrst_r5", rf[5], 8'h05);
    chk("midrst_idle", busy, 1'b0);

    // LDI r1,5; LDI r2,3; SUB r15,r1,r2; HALT.
    do_reset();
    rom[0] = 16'h6105;
    rom[1] = 16'h6203;
    rom[2] = 16'h2F12;
    rom[3] = 16'hF000;
    begin_run();
    for (int c = 1; c < 9; c++) tick();
    chk("prog_c9_we", write_enable, 1'b1);
    chk("prog_c9_wa", WA, 4'hF);
    chk("prog_c9_r15_old", rf[15], 8'h0F);
    tick();
    chk("prog_c10_r15", rf[15], 8'h02);
    chk("prog_r1", rf[1], 8'h05);
    chk("prog_r2", rf[2], 8'h03);
    tick();
    tick();
    chk("prog_c12_halted", halted, 1'b0);
    tick();
    chk("prog_c13_halted", halted, 1'b1);
    chk("prog_c13_busy", busy, 1'b0);
    tick();
    chk("prog_halt_stays", halted, 1'b1);
    begin_run();
    chk("restart_pc", pc, 8'h00);
    chk("restart_halted", halted, 1'b0);
    chk("restart_busy", busy, 1'b1);

    // JMP 0xFF then NOP at 0xFF: pc wraps to 0.
    do_reset();
    rom[0]   = 16'h70FF;
    rom[255] = 16'h0000;
    begin_run();
    tick();
    tick();
    tick();
    chk("jmp_pc_ff", pc, 8'hFF);
    tick();
    tick();
    tick();
    chk("wrap_pc_00", pc, 8'h00);
    rom[255] = 16'h0000;
    rom[1]   = 16'h0000;

    // start held high while busy has no effect.
    do_reset();
    rom[0] = 16'h6105;
    start  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("busy_start_pc", pc, 8'h01);
    chk("busy_start_busy", busy, 1'b1);
    start = 1'b0;

    // start and HALT together in EXEC: HALT wins, then start restarts.
    do_reset();
    rom[0] = 16'hF000;
    start  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("halt_wins_halted", halted, 1'b1);
    chk("halt_wins_busy", busy, 1'b0);
    tick();
    chk("halted_start_pc", pc, 8'h00);
    chk("halted_start_halted", halted, 1'b0);
    chk("halted_start_busy", busy, 1'b1);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
